tdma_address_calc: RTL and testbench
====================================

# tdma_address_calc

Four-dimensional address generator for the tensor DMA front end. On a start pulse it captures a base address, four per-dimension shapes and four per-dimension byte strides. It then emits one address per accepted update, walking the nested loop nest with dimension 1 innermost. Two instances run in lockstep inside the tensor DMA front end, one for source and one for destination; each transfer element is one contiguous byte run.

## Interface
Parameters:
- AddrWidth, 64, width of start and current address.
- DimWidth, 32, width of every shape and stride element.
- NumDims, 4, number of loop dimensions, indexed 1..NumDims.

Ports:
- clk_i  in  1  clock; all logic is on its rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_address_i  in  AddrWidth  base address of the transfer.
- shape_i[4:1]  in  DimWidth each  iteration count per dimension; index 1 is innermost.
- stride_i[4:1]  in  DimWidth each  byte increment per step of each dimension.
- start_new_transaction_i  in  1  single-cycle pulse that loads the inputs and restarts the walk.
- update_address_i  in  1  consumer accepts the current address and requests the next one.
- current_address_o  out  AddrWidth  address of the current element.
- valid_o  out  1  current_address_o holds an element still to be consumed.
- transaction_finished_o  out  1  all elements have been consumed; sticky.

## Operation
- Registered state:
  - captured shape and stride per dimension;
  - per-dimension index counters idx[k], each DimWidth bits;
  - per-dimension base addresses base[k], where base[k] is the address at which dimension k started its current sweep;
  - current address;
  - valid and finished flags.
- Shape handling: a captured shape of 0 is treated as 1, meaning the dimension is unused. Total element count is the product of the effective shapes.
- Address formula, for a decided fact check: address = start + Σ idx[k]·stride[k], computed modulo 2^AddrWidth.
  - Implement it incrementally; no multipliers.
- States:
  - IDLE: valid=0. This is the state after reset.
  - ACTIVE: valid=1.
  - DONE: valid=0, finished=1.
- Start, from any state:
  - Load the inputs, clear all idx[k], set every base[k] and the address to start_address_i.
  - valid←1, finished←0, go to ACTIVE.
- Update in ACTIVE:
  - Find the lowest k with idx[k] < shape[k]−1.
  - Set idx[k]++ and clear idx[j] for all j<k.
  - Compute new = base[k] + stride[k]. Set base[j] ← new for all j≤k, and address ← new.
- Last element: if no such k exists, the current element is the last one. Go to DONE: valid←0, finished←1. The address holds its last value.
- Ignored inputs:
  - update while IDLE or DONE is ignored.
  - update on the same cycle as start is ignored, because start wins.
- Abort: start while ACTIVE aborts the current walk and restarts with the new inputs.
- Overflow: address arithmetic wraps at 2^AddrWidth; no overflow flag.

## Timing
- Reset values: current_address_o=0, valid_o=0, transaction_finished_o=0, all counters and bases 0.
- Start latency: start at cycle t gives valid_o=1 and current_address_o=start_address_i at cycle t+1.
- Update latency: an update accepted at cycle t (valid_o=1, update_address_i=1) presents the next address at t+1. Throughput is one address per cycle.
- Handshake: valid/update is a simple accept. The consumer may hold update_address_i high continuously. The generator never stalls.
- Final update: the update accepted on the last element deasserts valid_o and asserts transaction_finished_o at t+1.
- Finish flag: transaction_finished_o stays high until the next start or reset.
- Mid-operation reset: reset asserted during ACTIVE immediately and asynchronously forces all outputs to their reset values.
- Input sampling: inputs other than start and update are sampled only on the start cycle; later changes have no effect.

## Configuration
- TDMA_ADDR_CALC_SIGNED_STRIDE_EN defined: strides are two's-complement and sign-extended to AddrWidth, which allows backward walks.
- Macro undefined: strides are unsigned and zero-extended to AddrWidth.

## Test plan
- Reset then idle: hold rst_i, then release without start → valid_o=0, finished=0, address=0; updates have no effect.
- 2-D walk:
  - Stimulus: start=0x1000, shape={1,1,2,3} (dims 4..1), stride1=0x10, stride2=0x100, update held high.
  - Response: addresses 0x1000, 0x1010, 0x1020, 0x1100, 0x1110, 0x1120 on consecutive cycles, then valid=0 and finished=1 on the next cycle.
- Zero shapes: all shapes=0, start=0x40 → exactly one element, 0x40; finished one cycle after the update.
- Update gaps: 4-D walk with shapes all 2, strides 1/0x10/0x100/0x1000, and update toggled every other cycle → 16 addresses from 0x0000 to 0x1111 in nested order, each held until accepted.
- Negative stride:
  - Stimulus: stride1=0xFFFFFFF0, shape1=2, start=0x1000.
  - With the macro: second address is 0x0FF0.
  - Without the macro: second address is 0x1_0000_0FF0.
- Restart and precedence:
  - A start mid-walk restarts with address = new start on the next cycle.
  - Start and update on the same cycle: the update is ignored.
  - Reset mid-walk clears valid immediately.

Source files
------------

// File: rtl/tdma_address_calc.sv
// Four-dimensional nested-loop address generator, dimension 1 innermost.
// Define TDMA_ADDR_CALC_SIGNED_STRIDE_EN for sign-extended (backward) strides.
module tdma_address_calc #(
  parameter int AddrWidth = 64,
  parameter int DimWidth  = 32,
  parameter int NumDims   = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [AddrWidth-1:0]              start_address_i,
  input  logic [NumDims:1][DimWidth-1:0]    shape_i,
  input  logic [NumDims:1][DimWidth-1:0]    stride_i,
  input  logic                              start_new_transaction_i,
  input  logic                              update_address_i,
  output logic [AddrWidth-1:0]              current_address_o,
  output logic                              valid_o,
  output logic                              transaction_finished_o
);

  typedef enum logic [1:0] {
    Idle,
    Active,
    Done
  } state_e;

  state_e state_q, state_d;

  logic [NumDims:1][DimWidth-1:0]  shape_q, shape_d;
  logic [NumDims:1][DimWidth-1:0]  stride_q, stride_d;
  logic [NumDims:1][DimWidth-1:0]  idx_q, idx_d;
  logic [NumDims:1][AddrWidth-1:0] base_q, base_d;
  logic [AddrWidth-1:0]            addr_q, addr_d;
  logic [AddrWidth-1:0]            step_addr;
  logic [NumDims:1]                sel;
  logic                            found;
  logic                            below;

  function automatic logic [AddrWidth-1:0] ext(
    input logic [DimWidth-1:0] s
  );
`ifdef TDMA_ADDR_CALC_SIGNED_STRIDE_EN
    return AddrWidth'($signed(s));
`else
    return AddrWidth'(s);
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    shape_d   = shape_q;
    stride_d  = stride_q;
    idx_d     = idx_q;
    base_d    = base_q;
    addr_d    = addr_q;
    found     = 1'b0;
    below     = 1'b1;
    sel       = '0;
    step_addr = base_q[1];

    // Lowest dimension that can still advance; shapes 0 and 1 never step.
    for (int k = 1; k <= NumDims; k++) begin
      if (!found && shape_q[k] > DimWidth'(1) &&
          idx_q[k] < shape_q[k] - DimWidth'(1)) begin
        found     = 1'b1;
        sel[k]    = 1'b1;
        step_addr = base_q[k] + ext(stride_q[k]);
      end
    end

    if (start_new_transaction_i) begin
      shape_d  = shape_i;
      stride_d = stride_i;
      idx_d    = '0;
      for (int k = 1; k <= NumDims; k++) begin
        base_d[k] = start_address_i;
      end
      addr_d  = start_address_i;
      state_d = Active;
    end else if (state_q == Active && update_address_i) begin
      if (found) begin
        for (int j = 1; j <= NumDims; j++) begin
          if (below) begin
            base_d[j] = step_addr;
            if (sel[j]) begin
              idx_d[j] = idx_q[j] + DimWidth'(1);
              below    = 1'b0;
            end else begin
              idx_d[j] = '0;
            end
          end
        end
        addr_d = step_addr;
      end else begin
        state_d = Done;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= Idle;
      shape_q  <= '0;
      stride_q <= '0;
      idx_q    <= '0;
      base_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      shape_q  <= shape_d;
      stride_q <= stride_d;
      idx_q    <= idx_d;
      base_q   <= base_d;
      addr_q   <= addr_d;
    end
  end

  assign current_address_o      = addr_q;
  assign valid_o                = (state_q == Active);
  assign transaction_finished_o = (state_q == Done);

endmodule

// File: tb/tb_tdma_address_calc.sv
// Randomized and directed bench for tdma_address_calc against a
// nested-loop reference model of the address sequence.
module tb_tdma_address_calc;

  logic             clk = 1'b0;
  logic             rst;
  logic [63:0]      sa;
  logic [4:1][31:0] sh;
  logic [4:1][31:0] st;
  logic             start;
  logic             upd;
  logic [63:0]      addr;
  logic             valid;
  logic             fin;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];

  tdma_address_calc dut (
    .clk_i                  (clk),
    .rst_i                  (rst),
    .start_address_i        (sa),
    .shape_i                (sh),
    .stride_i               (st),
    .start_new_transaction_i(start),
    .update_address_i       (upd),
    .current_address_o      (addr),
    .valid_o                (valid),
    .transaction_finished_o (fin)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sx(input logic [31:0] s);
`ifdef TDMA_ADDR_CALC_SIGNED_STRIDE_EN
    return {{32{s[31]}}, s};
`else
    return {32'h0, s};
`endif
  endfunction

  // Element list: start + sum(i_k * stride_k), dimension 1 innermost.
  task automatic build_model();
    longint unsigned e[4:1];
    exp_q.delete();
    for (int k = 1; k <= 4; k++) e[k] = (sh[k] == 0) ? 1 : sh[k];
    for (longint unsigned i4 = 0; i4 < e[4]; i4++)
      for (longint unsigned i3 = 0; i3 < e[3]; i3++)
        for (longint unsigned i2 = 0; i2 < e[2]; i2++)
          for (longint unsigned i1 = 0; i1 < e[1]; i1++)
            exp_q.push_back(sa + i1 * sx(st[1]) + i2 * sx(st[2])
                               + i3 * sx(st[3]) + i4 * sx(st[4]));
  endtask

  task automatic launch(input bit with_upd, input bit scramble);
    build_model();
    start = 1'b1;
    upd   = with_upd;
    @(negedge clk);
    start = 1'b0;
    upd   = 1'b0;
    if (scramble) begin
      sa = {$urandom, $urandom};
      for (int k = 1; k <= 4; k++) begin
        sh[k] = $urandom;
        st[k] = $urandom;
      end
    end
  endtask

  // mode 0: update held, 1: every other cycle, 2: random
  task automatic drain(input int mode);
    int          cyc = 0;
    bit          u;
    logic [63:0] last = '0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      check("valid", {63'h0, valid}, 64'h1);
      check("addr", addr, exp_q[0]);
      last = exp_q[0];
      case (mode)
        0:       u = 1'b1;
        1:       u = cyc[0];
        default: u = ($urandom_range(0, 2) != 0);
      endcase
      upd = u;
      @(negedge clk);
      if (u) void'(exp_q.pop_front());
      cyc++;
    end
    if (exp_q.size() != 0) check("timeout", 64'h0, 64'h1);
    check("done_valid", {63'h0, valid}, 64'h0);
    check("done_fin", {63'h0, fin}, 64'h1);
    upd = 1'b1;
    repeat (2) @(negedge clk);
    upd = 1'b0;
    check("sticky_fin", {63'h0, fin}, 64'h1);
    check("hold_addr", addr, last);
  endtask

  task automatic clr();
    sa = '0;
    sh = '0;
    st = '0;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    upd   = 1'b0;
    clr();
    repeat (3) @(negedge clk);
    check("rst_addr", addr, 64'h0);
    check("rst_valid", {63'h0, valid}, 64'h0);
    check("rst_fin", {63'h0, fin}, 64'h0);
    rst = 1'b0;
    upd = 1'b1;
    repeat (3) @(negedge clk);
    upd = 1'b0;
    check("idle_addr", addr, 64'h0);
    check("idle_valid", {63'h0, valid}, 64'h0);
    check("idle_fin", {63'h0, fin}, 64'h0);

    // 2-D walk
    clr();
    sa = 64'h1000;
    sh[1] = 3; sh[2] = 2; sh[3] = 1; sh[4] = 1;
    st[1] = 32'h10; st[2] = 32'h100;
    launch(1'b0, 1'b0);
    check("2d_n", 64'(exp_q.size()), 64'd6);
    check("2d_e3", exp_q[3], 64'h1100);
    drain(0);

    // all shapes zero: single element
    clr();
    sa = 64'h40;
    launch(1'b0, 1'b0);
    drain(0);

    // 4-D with update gaps
    clr();
    for (int k = 1; k <= 4; k++) begin
      sh[k] = 2;
      st[k] = 32'h1 << (4 * (k - 1));
    end
    launch(1'b0, 1'b0);
    check("4d_last", exp_q[15], 64'h1111);
    drain(1);

    // negative stride
    clr();
    sa = 64'h1000;
    sh[1] = 2;
    st[1] = 32'hFFFF_FFF0;
    launch(1'b0, 1'b0);
`ifdef TDMA_ADDR_CALC_SIGNED_STRIDE_EN
    check("neg_ref", exp_q[1], 64'h0FF0);
`else
    check("neg_ref", exp_q[1], 64'h1_0000_0FF0);
`endif
    drain(0);

    // restart mid-walk with update on the start cycle
    clr();
    sa = 64'h2000;
    sh[1] = 4; sh[2] = 3;
    st[1] = 32'h8; st[2] = 32'h80;
    launch(1'b0, 1'b0);
    upd = 1'b1;
    repeat (3) @(negedge clk);
    sa = 64'h9000;
    st[1] = 32'h4;
    launch(1'b1, 1'b1);
    check("restart_addr", addr, 64'h9000);
    drain(2);

    // asynchronous reset mid-walk
    clr();
    sa = 64'h5000;
    sh[1] = 8;
    st[1] = 32'h1;
    launch(1'b0, 1'b0);
    upd = 1'b1;
    repeat (2) @(negedge clk);
    upd = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_valid", {63'h0, valid}, 64'h0);
    check("arst_addr", addr, 64'h0);
    check("arst_fin", {63'h0, fin}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // randomized walks, inputs scrambled after start
    for (int t = 0; t < 30; t++) begin
      sa = {$urandom, $urandom};
      for (int k = 1; k <= 4; k++) begin
        sh[k] = $urandom_range(0, 3);
        st[k] = $urandom;
      end
      launch(1'($urandom_range(0, 1)), 1'b1);
      drain(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
